// File: rtl/cascade_pkg.sv
// Shared definitions for the blocks that sit around the cascade_lake filter chain.
package cascade_pkg;

    localparam int DEFAULT_DATA_W   = 16;
    localparam int HALO_3X3_CASCADE = 4;

    // Output entry layout; the crop FIFO packs {data, eol, eof} in this order.
    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] data;
        logic                      eol;
        logic                      eof;
    } crop_entry_t;

endpackage

// File: rtl/cascade_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is read straight from the array
// so a word written on one edge is presented on the next cycle.
module cascade_sync_fifo
    import cascade_pkg::*;
#(
    parameter int ENTRY_W = DEFAULT_DATA_W + 2,
    parameter int DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic               empty,
    output logic               full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        wr_ptr_reg;
    logic [AW:0]        rd_ptr_reg;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic               do_pop;
    logic               do_push;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // When full, a same-cycle pop frees the slot the push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign head = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/cascade_out_crop.sv
// Crops the halo from the free-running cascade output, optionally normalises,
// and buffers kept pixels onto a ready/valid stream with row/frame markers.
module cascade_out_crop
    import cascade_pkg::*;
#(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int HALO       = HALO_3X3_CASCADE,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int NORM_SHIFT = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_eol,
    output logic              out_eof,
    output logic              frame_done,
    output logic              overflow
);

    localparam int COL_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int ENTRY_W = DATA_W + 2;

    logic [COL_W-1:0]   col_reg;
    logic [ROW_W-1:0]   row_reg;
    logic               overflow_reg;
    logic               frame_done_reg;
    logic               frame_done_next;

    logic               col_last;
    logic               row_last;
    logic               keep;
    logic               in_eol;
    logic               in_eof;
    logic [DATA_W-1:0]  in_shifted;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop_fire;
    logic               drop;

    assign col_last = (col_reg == COL_W'(IMG_W - 1));
    assign row_last = (row_reg == ROW_W'(IMG_H - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (in_valid) begin
            if (col_last) begin
                col_reg <= '0;
                row_reg <= row_last ? '0 : row_reg + ROW_W'(1);
            end else begin
                col_reg <= col_reg + COL_W'(1);
            end
        end
    end

    assign keep       = in_valid && (col_reg >= COL_W'(HALO)) && (row_reg >= ROW_W'(HALO));
    assign in_eol     = col_last;
    assign in_eof     = col_last && row_last;
    assign in_shifted = in_data >> NORM_SHIFT;
    assign push_entry = {in_shifted, in_eol, in_eof};

    assign out_valid = !fifo_empty;
    assign pop_fire  = out_valid && out_ready;
    assign drop      = keep && fifo_full && !pop_fire;

    cascade_sync_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (keep),
        .push_data (push_entry),
        .pop       (out_ready),
        .head      (head_entry),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Array contents are undefined until written, so the head is masked when empty.
    assign out_data = out_valid ? head_entry[ENTRY_W-1:2] : '0;
    assign out_eol  = out_valid && head_entry[1];
    assign out_eof  = out_valid && head_entry[0];

    // A dropped eof word still has to close the frame for downstream.
    assign frame_done_next = (pop_fire && head_entry[0]) || (drop && in_eof);

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            overflow_reg   <= overflow_reg | drop;
            frame_done_reg <= frame_done_next;
        end
    end

    assign overflow   = overflow_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_cascade_out_crop.sv
// Scoreboard bench: three crop instances (base, NORM_SHIFT=3, FIFO_DEPTH=4)
// on an 8x6 image; monitors pop expected entries as the DUTs present them.
module tb_cascade_out_crop;
    import cascade_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid_a = 0, in_valid_n = 0, in_valid_o = 0;
    logic        out_ready_a = 0, out_ready_n = 0, out_ready_o = 0;
    logic        out_valid_a, out_valid_n, out_valid_o;
    logic [15:0] out_data_a, out_data_n, out_data_o;
    logic        out_eol_a, out_eol_n, out_eol_o;
    logic        out_eof_a, out_eof_n, out_eof_o;
    logic        frame_done_a, frame_done_n, frame_done_o;
    logic        overflow_a, overflow_n, overflow_o;

    crop_entry_t q_a[$], q_n[$], q_o[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          fd_cnt_a = 0, fd_cnt_n = 0, fd_cnt_o = 0;
    bit          fd_exp_a = 0;

    always #5 clk = ~clk;

    cascade_out_crop #(.IMG_W(8), .IMG_H(6), .HALO(4), .DATA_W(16), .NORM_SHIFT(0), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_eol(out_eol_a), .out_eof(out_eof_a), .frame_done(frame_done_a), .overflow(overflow_a));

    cascade_out_crop #(.IMG_W(8), .IMG_H(6), .HALO(4), .DATA_W(16), .NORM_SHIFT(3), .FIFO_DEPTH(8)) dut_n (
        .clk(clk), .reset(reset), .in_valid(in_valid_n), .in_data(in_data),
        .out_valid(out_valid_n), .out_ready(out_ready_n), .out_data(out_data_n),
        .out_eol(out_eol_n), .out_eof(out_eof_n), .frame_done(frame_done_n), .overflow(overflow_n));

    cascade_out_crop #(.IMG_W(8), .IMG_H(6), .HALO(4), .DATA_W(16), .NORM_SHIFT(0), .FIFO_DEPTH(4)) dut_o (
        .clk(clk), .reset(reset), .in_valid(in_valid_o), .in_data(in_data),
        .out_valid(out_valid_o), .out_ready(out_ready_o), .out_data(out_data_o),
        .out_eol(out_eol_o), .out_eof(out_eof_o), .frame_done(frame_done_o), .overflow(overflow_o));

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic crop_entry_t mk(input logic [15:0] d, input logic eol, input logic eof);
        crop_entry_t e;
        e.data = d;
        e.eol  = eol;
        e.eof  = eof;
        return e;
    endfunction

    task automatic push_exp(input int which, input logic [15:0] d, input logic eol, input logic eof);
        case (which)
            0: q_a.push_back(mk(d, eol, eof));
            1: q_n.push_back(mk(d, eol, eof));
            default: q_o.push_back(mk(d, eol, eof));
        endcase
    endtask

    // Kept pixels of an 8x6 frame with halo 4: 36..39 and 44..47.
    task automatic exp_std(input int which);
        for (int r = 4; r < 6; r++)
            for (int c = 4; c < 8; c++)
                push_exp(which, 16'(r * 8 + c), c == 7, (c == 7) && (r == 5));
    endtask

    task automatic set_valid(input int which, input logic v);
        case (which)
            0: in_valid_a = v;
            1: in_valid_n = v;
            default: in_valid_o = v;
        endcase
    endtask

    task automatic drive_pixels(input int which, input int start, input int count,
                                input bit gaps, input bit fixed_en, input logic [15:0] fixed);
        for (int p = start; p < start + count; p++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                set_valid(which, 1'b0);
                @(posedge clk); #1;
            end
            in_data = fixed_en ? fixed : 16'(p);
            set_valid(which, 1'b1);
            @(posedge clk); #1;
        end
        set_valid(which, 1'b0);
    endtask

    task automatic wait_drain(input int which, input string name);
        int sz;
        for (int i = 0; i < 200; i++) begin
            sz = (which == 0) ? q_a.size() : (which == 1) ? q_n.size() : q_o.size();
            if (sz == 0) break;
            @(posedge clk); #1;
        end
        sz = (which == 0) ? q_a.size() : (which == 1) ? q_n.size() : q_o.size();
        chk(name, sz, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        crop_entry_t e;
        if (!reset) begin
            if (fd_exp_a || frame_done_a)
                chk("frame_done_a_timing", frame_done_a, fd_exp_a);
            fd_exp_a = 0;
            if (frame_done_a) fd_cnt_a++;
            if (out_valid_a && out_ready_a) begin
                if (q_a.size() == 0) chk("unexpected_pop_a", 1, 0);
                else begin
                    e = q_a.pop_front();
                    chk("data_a", out_data_a, e.data);
                    chk("eol_a", out_eol_a, e.eol);
                    chk("eof_a", out_eof_a, e.eof);
                    fd_exp_a = e.eof;
                end
            end
        end
    end

    always @(negedge clk) begin
        crop_entry_t e;
        if (!reset) begin
            if (frame_done_n) fd_cnt_n++;
            if (out_valid_n && out_ready_n) begin
                if (q_n.size() == 0) chk("unexpected_pop_n", 1, 0);
                else begin
                    e = q_n.pop_front();
                    chk("data_n", out_data_n, e.data);
                    chk("eol_n", out_eol_n, e.eol);
                    chk("eof_n", out_eof_n, e.eof);
                end
            end
        end
    end

    always @(negedge clk) begin
        crop_entry_t e;
        if (!reset) begin
            if (frame_done_o) fd_cnt_o++;
            if (out_valid_o && out_ready_o) begin
                if (q_o.size() == 0) chk("unexpected_pop_o", 1, 0);
                else begin
                    e = q_o.pop_front();
                    chk("data_o", out_data_o, e.data);
                    chk("eol_o", out_eol_o, e.eol);
                    chk("eof_o", out_eof_o, e.eof);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid_a, 0);
        chk("reset_out_data", out_data_a, 0);
        chk("reset_out_eol_eof", {out_eol_a, out_eof_a}, 0);
        chk("reset_frame_done", frame_done_a, 0);
        chk("reset_overflow", overflow_a, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Streaming pass
        $display("phase: streaming");
        fd0 = fd_cnt_a;
        out_ready_a = 1;
        exp_std(0);
        drive_pixels(0, 0, 48, 0, 0, 16'h0);
        wait_drain(0, "drain_stream");
        chk("stream_frame_done_count", fd_cnt_a - fd0, 1);

        // Backpressure hold then drain
        $display("phase: backpressure");
        fd0 = fd_cnt_a;
        out_ready_a = 0;
        exp_std(0);
        drive_pixels(0, 0, 48, 0, 0, 16'h0);
        chk("bp_out_valid", out_valid_a, 1);
        chk("bp_head_data", out_data_a, 36);
        chk("bp_overflow", overflow_a, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_hold_data", out_data_a, 36);
        chk("bp_hold_eol", out_eol_a, 0);
        out_ready_a = 1;
        repeat (8) @(posedge clk);
        #1;
        chk("bp_drain_one_per_cycle", q_a.size(), 0);
        chk("bp_empty_after_drain", out_valid_a, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("bp_frame_done_count", fd_cnt_a - fd0, 1);

        // Normalisation
        $display("phase: normalisation");
        out_ready_n = 1;
        for (int r = 4; r < 6; r++)
            for (int c = 4; c < 8; c++)
                push_exp(1, 16'h1FFF, c == 7, (c == 7) && (r == 5));
        drive_pixels(1, 0, 48, 0, 1, 16'hFFFF);
        wait_drain(1, "drain_norm");
        chk("norm_frame_done_count", fd_cnt_n, 1);

        // Overflow with a 4-entry FIFO
        $display("phase: overflow");
        out_ready_o = 0;
        for (int c = 4; c < 8; c++)
            push_exp(2, 16'(32 + c), c == 7, 1'b0);
        drive_pixels(2, 0, 44, 0, 0, 16'h0);
        chk("ovf_before_drop", overflow_o, 0);
        drive_pixels(2, 44, 1, 0, 0, 16'h0);
        chk("ovf_after_first_drop", overflow_o, 1);
        drive_pixels(2, 45, 3, 0, 0, 16'h0);
        chk("ovf_frame_done_pulse", frame_done_o, 1);
        chk("ovf_head_data", out_data_o, 36);
        @(posedge clk); #1;
        chk("ovf_frame_done_single", frame_done_o, 0);
        out_ready_o = 1;
        wait_drain(2, "drain_ovf");
        chk("ovf_sticky", overflow_o, 1);
        chk("ovf_frame_done_count", fd_cnt_o, 1);

        // Back-to-back frames with random gaps
        $display("phase: gapped frames");
        fd0 = fd_cnt_a;
        out_ready_a = 1;
        exp_std(0);
        exp_std(0);
        drive_pixels(0, 0, 48, 1, 0, 16'h0);
        drive_pixels(0, 0, 48, 1, 0, 16'h0);
        wait_drain(0, "drain_gaps");
        chk("gaps_frame_done_count", fd_cnt_a - fd0, 2);

        // Reset in the middle of a frame
        $display("phase: mid-frame reset");
        out_ready_a = 0;
        drive_pixels(0, 0, 40, 0, 0, 16'h0);
        chk("pre_reset_holding", out_valid_a, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("post_reset_out_valid", out_valid_a, 0);
        chk("post_reset_overflow_a", overflow_a, 0);
        chk("post_reset_overflow_o", overflow_o, 0);
        fd0 = fd_cnt_a;
        out_ready_a = 1;
        exp_std(0);
        drive_pixels(0, 0, 48, 0, 0, 16'h0);
        wait_drain(0, "drain_after_reset");
        chk("reset_frame_done_count", fd_cnt_a - fd0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
